lbm_stream_addr_gen: RTL and testbench
======================================

Name: lbm_stream_addr_gen

Overview:
- Streaming-step address generator for the D2Q9 LBM core.
- Sweeps every lattice node and every direction, and drives Dir_Idx to the velocity ROM. The ROM output feeds the sign_extender, whose 9-bit signed cx/cy return here.
- Computes the periodic-wrapped destination node and its linear distribution-memory address for each (node, direction), then emits it over a valid/ready handshake to the memory write stage.

Parameters:
NX, 64, lattice width in nodes (>=2)
NY, 32, lattice height in nodes (>=2)
Q, 9, number of lattice directions
XW, 8, coordinate width; 2**XW >= max(NX,NY)
CW, 9, width of signed cx/cy from sign_extender; |cx| < NX and |cy| < NY required
AW, 16, address width; 2**AW >= Q*NX*NY

Ports:
Clk  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-high; clears all state
Start  input  1  single-cycle pulse; begins a sweep (sampled only in IDLE)
Dir_Idx  output  4  current direction index to velocity ROM (combinational from q counter)
Cx_Ext  input  CW  signed cx for Dir_Idx, same cycle (combinational ROM + sign_extender path)
Cy_Ext  input  CW  signed cy for Dir_Idx, same cycle
Src_X  output  XW  source node x
Src_Y  output  XW  source node y
Dst_X  output  XW  wrapped destination x
Dst_Y  output  XW  wrapped destination y
Dir_Out  output  4  direction of this beat
Dst_Addr  output  AW  Dir_Out*NX*NY + Dst_Y*NX + Dst_X
Addr_Valid  output  1  output beat valid
Addr_Ready  input  1  downstream accepts beat
Busy  output  1  high in RUN and DRAIN
Done  output  1  one-cycle pulse on final handshake

Behaviour:
- Reset (async, any state): state=IDLE; x=y=q=0; all outputs 0, including Addr_Valid, Busy, Done and Dir_Idx.
- Output register group: Src_X, Src_Y, Dst_X, Dst_Y, Dir_Out, Dst_Addr, Addr_Valid.
- Handshake: a beat transfers on a rising edge with Addr_Valid&&Addr_Ready. While Addr_Valid=1 and Addr_Ready=0, the output register group holds stable.
- Load enable: load = (state==RUN) && (!Addr_Valid || Addr_Ready).
- Iteration order: q innermost (0..Q-1), then x (0..NX-1), then y (0..NY-1).
- Counter advance: q,x,y advance only on load. On wrap of the last q at x=NX-1, y=NY-1, the counters return to 0.
- Wrap arithmetic: sx = x + Cx_Ext, signed, CW+1 bits.
  - If sx<0: Dst_X = sx+NX.
  - Else if sx>=NX: Dst_X = sx-NX.
  - Else: Dst_X = sx.
  - Same rule for y with NY.
  - No other modulo is performed; the out-of-range cx/cy limits above are caller guarantees.
- Dst_Addr uses the wrapped coordinates; compute in AW bits, no truncation.
- FSM:
  - IDLE: Start=1 -> RUN with counters at 0. Otherwise stay. Addr_Valid=0.
  - RUN: on the load that captures the final (x=NX-1, y=NY-1, q=Q-1) element -> DRAIN.
  - DRAIN: no new loads. When Addr_Valid&&Addr_Ready: Addr_Valid->0, Done=1 for that next cycle, -> IDLE.
- Latency: Start at edge k -> RUN at k. First beat loads at edge k+1, so Addr_Valid=1 after k+1. With Addr_Ready held high, one beat per cycle.
- Beat count: Q*NX*NY beats per sweep, exactly once each, none duplicated or skipped under any Addr_Ready pattern.
- Start while Busy: ignored.
- Start on the same cycle Done is high: state is IDLE that cycle, so it is accepted.
- Busy=1 exactly in RUN and DRAIN.
- Reset mid-sweep: all state immediately cleared. The next Start begins from node (0,0), q=0.

Test Plan:
- Bench setup: NX=4, NY=3, Q=9, standard D2Q9 ROM in the bench.
  - Direction 0..8: (0,0),(1,0),(0,1),(-1,0),(0,-1),(1,1),(-1,1),(-1,-1),(1,-1).
- Full sweep: Start pulse, Addr_Ready=1 -> 108 consecutive beats.
  - Beat 0: Src=(0,0), Dir 0, Dst=(0,0), Dst_Addr=0.
  - Done pulses on the cycle after beat 108; Busy is low thereafter.
- Negative wrap: node (0,0), Dir 7 (-1,-1) -> Dst=(3,2), Dst_Addr=7*12+2*4+3=95.
- Positive wrap: node (3,2), Dir 5 (1,1) -> Dst=(0,0), Dst_Addr=60.
- Backpressure: random Addr_Ready (50%) -> outputs stable while stalled; still exactly 108 unique beats matching the reference-model sequence; one Done.
- Start while Busy: pulse Start at beat 40 -> no restart; beat 41 follows in order; total beats 108.
- Async reset mid-sweep: assert Reset at beat 50, deassert, Start -> Addr_Valid=0, Busy=0 immediately on reset; new sweep begins at Src=(0,0), Dir 0.

Source files
------------

// File: rtl/lbm_stream_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module   : lbm_stream_addr_gen
//  Purpose  : D2Q9 LBM streaming-step address generator. Sweeps every
//             (node, direction) pair and looks up each direction's velocity
//             through an external ROM + sign extender. It wraps the
//             destination node periodically and emits the linear
//             distribution-memory address over a valid/ready handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module lbm_stream_addr_gen #(
  parameter int NX = 64,
  parameter int NY = 32,
  parameter int Q  = 9,
  parameter int XW = 8,
  parameter int CW = 9,
  parameter int AW = 16
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Start,
  output logic [3:0]           Dir_Idx,
  input  logic signed [CW-1:0] Cx_Ext,
  input  logic signed [CW-1:0] Cy_Ext,
  output logic [XW-1:0]        Src_X,
  output logic [XW-1:0]        Src_Y,
  output logic [XW-1:0]        Dst_X,
  output logic [XW-1:0]        Dst_Y,
  output logic [3:0]           Dir_Out,
  output logic [AW-1:0]        Dst_Addr,
  output logic                 Addr_Valid,
  input  logic                 Addr_Ready,
  output logic                 Busy,
  output logic                 Done
);

  // FSM encoding
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  // Signed working width: must hold an unsigned coordinate plus a signed
  // velocity without overflow, with one bit of headroom for the sum.
  localparam int SW = (((XW + 1) > CW) ? (XW + 1) : CW) + 1;

  localparam logic [3:0]           C_Q_LAST = 4'(Q - 1);
  localparam logic [XW-1:0]        C_X_LAST = XW'(NX - 1);
  localparam logic [XW-1:0]        C_Y_LAST = XW'(NY - 1);
  localparam logic signed [SW-1:0] C_NX_S   = SW'(NX);
  localparam logic signed [SW-1:0] C_NY_S   = SW'(NY);
  localparam logic [AW-1:0]        C_NX_A   = AW'(NX);
  localparam logic [AW-1:0]        C_PLANE  = AW'(NX * NY);

  // State and counters
  logic [1:0]    state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [XW-1:0] y_q, y_d;
  logic [3:0]    q_q, q_d;

  // Output register group
  logic [XW-1:0] src_x_q, src_x_d;
  logic [XW-1:0] src_y_q, src_y_d;
  logic [XW-1:0] dst_x_q, dst_x_d;
  logic [XW-1:0] dst_y_q, dst_y_d;
  logic [3:0]    dir_q, dir_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          valid_q, valid_d;
  logic          done_q, done_d;

  // Datapath wires
  logic signed [SW-1:0] sx_w, sy_w;
  logic signed [SW-1:0] wx_w, wy_w;
  logic [XW-1:0]        dst_x_w, dst_y_w;
  logic [AW-1:0]        addr_w;
  logic                 load_w;
  logic                 last_w;

  // Periodic wrap of the destination node and its linear address
  always_comb begin
    sx_w = $signed({{(SW - XW){1'b0}}, x_q}) + $signed({{(SW - CW){Cx_Ext[CW-1]}}, Cx_Ext});
    sy_w = $signed({{(SW - XW){1'b0}}, y_q}) + $signed({{(SW - CW){Cy_Ext[CW-1]}}, Cy_Ext});

    if (sx_w < 0)
      wx_w = sx_w + C_NX_S;
    else if (sx_w >= C_NX_S)
      wx_w = sx_w - C_NX_S;
    else
      wx_w = sx_w;

    if (sy_w < 0)
      wy_w = sy_w + C_NY_S;
    else if (sy_w >= C_NY_S)
      wy_w = sy_w - C_NY_S;
    else
      wy_w = sy_w;

    dst_x_w = wx_w[XW-1:0];
    dst_y_w = wy_w[XW-1:0];
    addr_w  = (AW'(q_q) * C_PLANE) + (AW'(dst_y_w) * C_NX_A) + AW'(dst_x_w);
  end

  // Next-state, counter and output-register logic
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    q_d     = q_q;
    src_x_d = src_x_q;
    src_y_d = src_y_q;
    dst_x_d = dst_x_q;
    dst_y_d = dst_y_q;
    dir_d   = dir_q;
    addr_d  = addr_q;
    valid_d = valid_q;
    done_d  = 1'b0;

    // The output register may reload when empty or when its beat leaves.
    load_w = (state_q == S_RUN) && (!valid_q || Addr_Ready);
    last_w = (q_q == C_Q_LAST) && (x_q == C_X_LAST) && (y_q == C_Y_LAST);

    case (state_q)
      S_IDLE: begin
        if (Start) begin
          state_d = S_RUN;
          x_d     = '0;
          y_d     = '0;
          q_d     = '0;
        end
      end

      S_RUN: begin
        if (load_w) begin
          src_x_d = x_q;
          src_y_d = y_q;
          dst_x_d = dst_x_w;
          dst_y_d = dst_y_w;
          dir_d   = q_q;
          addr_d  = addr_w;
          valid_d = 1'b1;

          // q innermost, then x, then y; everything returns to 0 at the end
          if (q_q == C_Q_LAST) begin
            q_d = '0;
            if (x_q == C_X_LAST) begin
              x_d = '0;
              if (y_q == C_Y_LAST)
                y_d = '0;
              else
                y_d = y_q + 1'b1;
            end else begin
              x_d = x_q + 1'b1;
            end
          end else begin
            q_d = q_q + 1'b1;
          end

          if (last_w)
            state_d = S_DRAIN;
        end
      end

      S_DRAIN: begin
        if (valid_q && Addr_Ready) begin
          valid_d = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // State register with asynchronous clear
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      q_q     <= '0;
      src_x_q <= '0;
      src_y_q <= '0;
      dst_x_q <= '0;
      dst_y_q <= '0;
      dir_q   <= '0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      q_q     <= q_d;
      src_x_q <= src_x_d;
      src_y_q <= src_y_d;
      dst_x_q <= dst_x_d;
      dst_y_q <= dst_y_d;
      dir_q   <= dir_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  // Output mapping
  always_comb begin
    Dir_Idx    = q_q;
    Src_X      = src_x_q;
    Src_Y      = src_y_q;
    Dst_X      = dst_x_q;
    Dst_Y      = dst_y_q;
    Dir_Out    = dir_q;
    Dst_Addr   = addr_q;
    Addr_Valid = valid_q;
    Busy       = (state_q == S_RUN) || (state_q == S_DRAIN);
    Done       = done_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_lbm_stream_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lbm_stream_addr_gen
//  Purpose  : Directed bench for lbm_stream_addr_gen on a 4x3 D2Q9 lattice.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lbm_stream_addr_gen;

  localparam int NX = 4;
  localparam int NY = 3;
  localparam int Q  = 9;
  localparam int XW = 8;
  localparam int CW = 9;
  localparam int AW = 16;
  localparam int NBEATS = Q * NX * NY;

  localparam int CXT [9] = '{0, 1, 0, -1, 0, 1, -1, -1, 1};
  localparam int CYT [9] = '{0, 0, 1, 0, -1, 1, 1, -1, -1};

  logic                 clk;
  logic                 rst;
  logic                 start;
  logic [3:0]           dir_idx;
  logic signed [CW-1:0] cx_ext;
  logic signed [CW-1:0] cy_ext;
  logic [XW-1:0]        src_x, src_y, dst_x, dst_y;
  logic [3:0]           dir_out;
  logic [AW-1:0]        dst_addr;
  logic                 addr_valid;
  logic                 addr_ready;
  logic                 busy;
  logic                 done;

  int checks = 0;
  int errors = 0;

  lbm_stream_addr_gen #(
    .NX(NX), .NY(NY), .Q(Q), .XW(XW), .CW(CW), .AW(AW)
  ) dut (
    .Clk(clk),
    .Reset(rst),
    .Start(start),
    .Dir_Idx(dir_idx),
    .Cx_Ext(cx_ext),
    .Cy_Ext(cy_ext),
    .Src_X(src_x),
    .Src_Y(src_y),
    .Dst_X(dst_x),
    .Dst_Y(dst_y),
    .Dir_Out(dir_out),
    .Dst_Addr(dst_addr),
    .Addr_Valid(addr_valid),
    .Addr_Ready(addr_ready),
    .Busy(busy),
    .Done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Velocity ROM plus sign extension, combinational from Dir_Idx
  always_comb begin
    cx_ext = '0;
    cy_ext = '0;
    if (dir_idx < 4'd9) begin
      cx_ext = CW'(CXT[dir_idx]);
      cy_ext = CW'(CYT[dir_idx]);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference beat i: {Src_X, Src_Y, Dst_X, Dst_Y, Dir, Addr}
  function automatic logic [51:0] exp_beat(input int i);
    int q, n, x, y, dx, dy;
    q  = i % Q;
    n  = i / Q;
    x  = n % NX;
    y  = n / NX;
    dx = (x + CXT[q] + NX) % NX;
    dy = (y + CYT[q] + NY) % NY;
    return {8'(x), 8'(y), 8'(dx), 8'(dy), 4'(q), 16'(q * NX * NY + dy * NX + dx)};
  endfunction

  function automatic logic [51:0] cur_beat();
    return {src_x, src_y, dst_x, dst_y, dir_out, dst_addr};
  endfunction

  task automatic pulse_start();
    addr_ready = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Consume beats until Done has pulsed (or stop_at beats seen).
  // mode 0: ready always high; mode 1: random ready.
  task automatic collect(input int mode, input int start_at, input int stop_at,
                         output int nb, output int nd);
    logic [51:0] prev, cur;
    bit stalled, issued, finished;
    int cyc;
    nb = 0; nd = 0; stalled = 0; issued = 0; finished = 0; cyc = 0;
    prev = '0;
    while (!finished && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      cur = cur_beat();
      if (stalled) check("stall_hold", 64'(cur), 64'(prev));
      if (done) nd++;
      if (nd > 0 && !done) begin
        finished = 1;
      end else if (stop_at >= 0 && nb == stop_at) begin
        finished = 1;
      end else begin
        start = 1'b0;
        if (!issued && start_at >= 0 && nb == start_at && addr_valid) begin
          start  = 1'b1;
          issued = 1;
        end
        addr_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
        if (addr_valid && addr_ready) begin
          check($sformatf("beat%0d", nb), 64'(cur), 64'(exp_beat(nb)));
          if (nb == 7)
            check("neg_wrap", {32'd0, dst_x, dst_y, dst_addr}, {32'd0, 8'd3, 8'd2, 16'd95});
          if (nb == 104)
            check("pos_wrap", {32'd0, dst_x, dst_y, dst_addr}, {32'd0, 8'd0, 8'd0, 16'd60});
          nb++;
        end
        stalled = addr_valid && !addr_ready;
        prev    = cur;
      end
    end
    start = 1'b0;
    if (!finished) check("timeout", 64'(cyc), 64'd0);
  endtask

  initial begin
    int nb, nd;
    rst        = 1'b1;
    start      = 1'b0;
    addr_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_valid", 64'(addr_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_dir_idx", 64'(dir_idx), 64'd0);
    check("rst_beat", 64'(cur_beat()), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_busy", 64'(busy), 64'd0);

    // Sweep 1: latency then full sweep with ready high
    pulse_start();
    check("lat_busy", 64'(busy), 64'd1);
    check("lat_valid0", 64'(addr_valid), 64'd0);
    @(negedge clk);
    check("lat_valid1", 64'(addr_valid), 64'd1);
    check("beat0_addr", 64'(dst_addr), 64'd0);
    collect(0, -1, -1, nb, nd);
    check("s1_beats", 64'(nb), 64'(NBEATS));
    check("s1_done", 64'(nd), 64'd1);
    check("s1_busy_after", 64'(busy), 64'd0);
    check("s1_valid_after", 64'(addr_valid), 64'd0);

    // Sweep 2: random backpressure
    pulse_start();
    collect(1, -1, -1, nb, nd);
    check("s2_beats", 64'(nb), 64'(NBEATS));
    check("s2_done", 64'(nd), 64'd1);

    // Sweep 3: Start pulsed while busy
    pulse_start();
    collect(0, 40, -1, nb, nd);
    check("s3_beats", 64'(nb), 64'(NBEATS));
    check("s3_done", 64'(nd), 64'd1);

    // Sweep 4: asynchronous reset mid-sweep, then a fresh sweep
    pulse_start();
    collect(0, -1, 50, nb, nd);
    check("s4_partial", 64'(nb), 64'd50);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_valid", 64'(addr_valid), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_dir_idx", 64'(dir_idx), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    pulse_start();
    collect(0, -1, -1, nb, nd);
    check("s5_beats", 64'(nb), 64'(NBEATS));
    check("s5_done", 64'(nd), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
